wb_port_arbiter: RTL and testbench

- Shares the single integer register-file write port between two sources.
  - The in-order pipeline writeback, taken from the MEM/WB register outputs.
  - A long-latency unit (multi-cycle divider/multiplier) whose results complete out of band.
- Long-latency results are buffered in a small FIFO.
- The pipeline has priority, with a starvation limit. When the limit is reached, the arbiter stalls the pipeline for one cycle to drain one buffered result.
- Sits between the WB stage and the register file write port.

---
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 tb/tb_wb_port_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between pipeline writeback
//            and a FIFO of long-latency results, with a starvation limit.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_wr_en,
   input  logic [ADDR_W-1:0]        pipe_rd_addr,
   input  logic [DATA_W-1:0]        pipe_wr_data,
   output logic                     pipe_stall,
   input  logic                     lu_valid,
   input  logic [ADDR_W-1:0]        lu_rd_addr,
   input  logic [DATA_W-1:0]        lu_data,
   output logic                     lu_ready,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;
   localparam int c_SC_W  = $clog2(STARVE_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT  = c_CNT_W'(DEPTH);
   localparam logic [c_SC_W-1:0]  c_STARVE_MAX = c_SC_W'(STARVE_MAX);

   logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
   logic [DATA_W-1:0]  r_mem_data [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [c_SC_W-1:0]  r_starve_cnt;

   logic w_pipe_req;
   logic w_fifo_ne;
   logic w_grant_fifo;
   logic w_grant_pipe;
   logic w_push;

   always_comb begin
      w_pipe_req   = pipe_wr_en && (pipe_rd_addr != '0);
      w_fifo_ne    = (r_count != '0);
      w_grant_fifo = w_fifo_ne && (!w_pipe_req || (r_starve_cnt == c_STARVE_MAX));
      w_grant_pipe = w_pipe_req && !w_grant_fifo;
      lu_ready     = (r_count < c_DEPTH_CNT);
      // x0 results complete the handshake but are never stored
      w_push       = lu_valid && lu_ready && (lu_rd_addr != '0);
      pipe_stall   = w_pipe_req && w_grant_fifo;
      fifo_count   = r_count;
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= lu_rd_addr;
         r_mem_data[r_wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_starve_cnt <= '0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_grant_fifo) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_grant_fifo})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (!w_fifo_ne || w_grant_fifo) begin
            r_starve_cnt <= '0;
         end else if (w_grant_pipe && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end

         rf_we <= w_grant_pipe || w_grant_fifo;
         if (w_grant_pipe) begin
            rf_waddr <= pipe_rd_addr;
            rf_wdata <= pipe_wr_data;
         end else if (w_grant_fifo) begin
            rf_waddr <= r_mem_addr[r_rd_ptr];
            rf_wdata <= r_mem_data[r_rd_ptr];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed scoreboard bench for wb_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_wr_en = 1'b0;
   logic [4:0]  pipe_rd_addr = '0;
   logic [31:0] pipe_wr_data = '0;
   logic        pipe_stall;
   logic        lu_valid = 1'b0;
   logic [4:0]  lu_rd_addr = '0;
   logic [31:0] lu_data = '0;
   logic        lu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  fifo_count;

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .pipe_wr_en(pipe_wr_en), .pipe_rd_addr(pipe_rd_addr), .pipe_wr_data(pipe_wr_data),
      .pipe_stall(pipe_stall),
      .lu_valid(lu_valid), .lu_rd_addr(lu_rd_addr), .lu_data(lu_data), .lu_ready(lu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t q[$];
   int  n_vec  = 0;
   int  n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every register-file write must match the next expected write.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rf_write: got addr %0d data %h expected no write (t=%0t)",
                     rf_waddr, rf_wdata, $time);
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
            chk("rf_wdata", rf_wdata, e.d);
         end
      end
   end

   // One cycle: drive after the edge, check combinational outputs mid-cycle,
   // and queue the write the arbiter should issue at the next edge.
   task automatic cyc(input logic r, input logic pe, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic e_stall, input logic e_ready, input logic [1:0] e_cnt,
                      input logic e_wr, input logic [4:0] e_a, input logic [31:0] e_d);
      @(posedge clk);
      #1;
      rst = r; pipe_wr_en = pe; pipe_rd_addr = prd; pipe_wr_data = pd;
      lu_valid = lv; lu_rd_addr = lrd; lu_data = ld;
      @(negedge clk);
      chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
      chk("lu_ready",   32'(lu_ready),   32'(e_ready));
      chk("fifo_count", 32'(fifo_count), 32'(e_cnt));
      if (e_wr) q.push_back('{a: e_a, d: e_d});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      // reset then idle
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);
      chk("reset rf_we", 32'(rf_we), 0);
      chk("reset rf_waddr", 32'(rf_waddr), 0);
      chk("reset rf_wdata", rf_wdata, 0);

      // pipeline only, then write to x0
      cyc(0, 1, 5, 32'h1234, 0, 0, 0,               0, 1, 0, 1, 5, 32'h1234);
      cyc(0, 1, 0, 32'hFFFF, 0, 0, 0,               0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);
      chk("x0 pipe no write", 32'(rf_we), 0);

      // LU entries 7, 9 queued behind pipeline traffic, then drain in order
      cyc(0, 1, 1, 32'h11, 1, 7, 32'hAAAA,          0, 1, 0, 1, 1, 32'h11);
      cyc(0, 1, 2, 32'h22, 1, 9, 32'hBBBB,          0, 1, 1, 1, 2, 32'h22);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 0, 2, 1, 7, 32'hAAAA);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 1, 1, 9, 32'hBBBB);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);

      // starvation: 4 pipeline grants, one stall, LU write, held request
      cyc(0, 0, 0, 0, 1, 3, 32'h3333,               0, 1, 0, 0, 0, 0);
      cyc(0, 1, 10, 32'hA0, 0, 0, 0,                0, 1, 1, 1, 10, 32'hA0);
      cyc(0, 1, 11, 32'hA1, 0, 0, 0,                0, 1, 1, 1, 11, 32'hA1);
      cyc(0, 1, 12, 32'hA2, 0, 0, 0,                0, 1, 1, 1, 12, 32'hA2);
      cyc(0, 1, 13, 32'hA3, 0, 0, 0,                0, 1, 1, 1, 13, 32'hA3);
      cyc(0, 1, 14, 32'hA4, 0, 0, 0,                1, 1, 1, 1, 3, 32'h3333);
      cyc(0, 1, 14, 32'hA4, 0, 0, 0,                0, 1, 0, 1, 14, 32'hA4);

      // starve counter back at 0: a fresh entry waits 4 more pipeline grants
      cyc(0, 1, 15, 32'hB0, 1, 2, 32'h2222,         0, 1, 0, 1, 15, 32'hB0);
      cyc(0, 1, 16, 32'hB1, 0, 0, 0,                0, 1, 1, 1, 16, 32'hB1);
      cyc(0, 1, 17, 32'hB2, 0, 0, 0,                0, 1, 1, 1, 17, 32'hB2);
      cyc(0, 1, 18, 32'hB3, 0, 0, 0,                0, 1, 1, 1, 18, 32'hB3);
      cyc(0, 1, 19, 32'hB4, 0, 0, 0,                0, 1, 1, 1, 19, 32'hB4);
      cyc(0, 1, 20, 32'hB5, 0, 0, 0,                1, 1, 1, 1, 2, 32'h2222);
      cyc(0, 1, 20, 32'hB5, 0, 0, 0,                0, 1, 0, 1, 20, 32'hB5);

      // full FIFO: push refused while popping, accepted next cycle
      cyc(0, 1, 21, 32'hC0, 1, 4, 32'h4444,         0, 1, 0, 1, 21, 32'hC0);
      cyc(0, 1, 22, 32'hC1, 1, 6, 32'h6666,         0, 1, 1, 1, 22, 32'hC1);
      cyc(0, 0, 0, 0, 1, 8, 32'h8888,               0, 0, 2, 1, 4, 32'h4444);
      cyc(0, 0, 0, 0, 1, 8, 32'h8888,               0, 1, 1, 1, 6, 32'h6666);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 1, 1, 8, 32'h8888);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);

      // LU result to x0: handshake only
      cyc(0, 0, 0, 0, 1, 0, 32'hDEAD,               0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);

      // reset mid-drain with two entries queued
      cyc(0, 1, 23, 32'hD0, 1, 11, 32'hB1B1,        0, 1, 0, 1, 23, 32'hD0);
      cyc(0, 1, 24, 32'hD1, 1, 12, 32'hB2B2,        0, 1, 1, 1, 24, 32'hD1);
      cyc(1, 0, 0, 0, 0, 0, 0,                      0, 0, 2, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);
      chk("mid reset rf_we", 32'(rf_we), 0);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0,                      0, 1, 0, 0, 0, 0);

      chk("scoreboard drained", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
